multicycle_control_fsm: RTL
===========================

// Module: multicycle_control_fsm
// PURPOSE
// - Multicycle control FSM that sequences the control-less datapath (PC/SP/memory block plus register block and ALU).
// - Decodes instruction[15:12], drives every datapath select and enable per state, and traps to kernel mode on ALU overflow.
// PARAMETERS
// TRAP_ON_OVF  1      1: ALU overflow in EXEC enters TRAP; 0: overflow is ignored
// HALT_OP      4'hF   opcode that enters HALT
// PORTS
// clock          in   1   system clock; all state changes on the rising edge
// reset          in   1   asynchronous, active-low reset
// instruction    in   16  instruction register contents from the datapath
// overflow       in   1   ALU overflow flag, valid in EXEC
// comp_zero      in   1   1 when comp == 0 (derived at top level)
// MemWrite       out  1   memory write strobe
// MemSrc         out  2   address select: 0=PC, 1=SP, 2=comp
// MemDst         out  3   memory write-data select: 0=mary, 1=shelley, 2=ra, 3=comp
// PCSrc          out  4   0=PC+2, 1=PC+sext_imm, 2=zext_imm, 3=ra, 4=trap vector
// SPSrc          out  2   0=SP-2, 1=SP+2, 2=sext_ls_imm
// PCWrite        out  1   PC load enable
// SPWrite        out  1   SP load enable
// InstWrite      out  1   instruction register load enable
// mary_write     out  1   mary register write enable
// shelley_write  out  1   shelley register write enable
// comp_write     out  1   comp register write enable
// ra_write       out  1   ra register write enable
// mary_src       out  3   mary data select: 0=comp, 1=memval, 2=zext_imm
// shelley_src    out  2   shelley data select: 0=comp, 1=memval
// ra_src         out  1   ra data select: 0=PC, 1=memval
// SrcA           out  1   ALU A select: 0=mary, 1=PC
// SrcB           out  2   ALU B select: 0=shelley, 1=sext_imm, 2=zext_imm
// AluOp          out  4   ALU operation; 0=add, 1=sub
// in_kernel      out  1   kernel-mode flag, driven to the datapath
// halted         out  1   1 while in HALT
// BEHAVIOUR
// - Reset (async, reset==0): state=FETCH, in_kernel=0, halted=0. All enables 0, all selects 0 while reset is held.
// - Outputs are Moore-decoded from state and the latched opcode. Any output not listed for a state is 0.
// - Reset asserted mid-instruction aborts the instruction; no partial write occurs after the reset edge.
// - FETCH: MemSrc=0, InstWrite=1, PCWrite=1, PCSrc=0. Next state DECODE.
// - DECODE: opcode latched. 0/1/2/3/5/6/7 -> EXEC; HALT_OP -> HALT; any other opcode -> TRAP.
// - EXEC:
//   - op0 ALU-R: SrcA=0, SrcB=0, AluOp=instruction[5:2], comp_write=1.
//   - op1 ALU-I: SrcB=1, AluOp=0, comp_write=1.
//   - op2 LOAD, op3 STORE: SrcB=1, comp_write=1 (address); then MEM.
//   - op5 BEQZ: if comp_zero, PCWrite=1 and PCSrc=1; then FETCH.
//   - op6 JAL: ra_write=1, ra_src=0, PCWrite=1, PCSrc=2; then FETCH.
//   - op7 JR: PCWrite=1, PCSrc=3; then FETCH.
//   - op0/op1: if overflow and TRAP_ON_OVF, go to TRAP with comp_write still 1; otherwise WB.
// - MEM: MemSrc=2.
//   - LOAD: mary_write=1, mary_src=1; then FETCH.
//   - STORE: MemWrite=1, MemDst=0; then FETCH.
// - WB: mary_write=1, mary_src=0; then FETCH.
// - TRAP: PCWrite=1, PCSrc=4. in_kernel is set on exit. Next FETCH.
//   - Trap while in_kernel==1 (nested) -> HALT instead.
// - HALT: halted=1, all enables 0. Exits only via reset.
// - Latency: ALU = 4 cycles (FETCH, DECODE, EXEC, WB); LOAD/STORE = 4; branch/jump = 3.
// TESTING
// - Release reset with instruction=0x1004 (ALU-I) -> states FETCH,DECODE,EXEC,WB; comp_write in cycle 3, mary_write in cycle 4.
// - BEQZ 0x5008: comp_zero=1 -> PCWrite=1, PCSrc=1 in EXEC; comp_zero=0 -> PCWrite=0.
// - STORE 0x3004 -> exactly one MemWrite pulse, in MEM, with MemSrc=2.
// - ALU-R with overflow=1 -> TRAP, PCSrc=4, in_kernel=1; a second overflow -> halted=1.
// - Opcode 0xF -> halted=1 and stays; reset pulsed low mid-EXEC -> FETCH, all outputs 0.

Source files
------------

// File: rtl/multicycle_control_fsm.sv
// Multicycle control FSM for the control-less datapath (PC/SP/memory block,
// register block and ALU). The FSM decodes instruction[15:12], drives every
// datapath select and enable for the current state, and traps to kernel mode
// on ALU overflow. A trap taken while already in kernel mode halts the core.
//
// Ports
//   clock          system clock, rising edge active
//   reset          asynchronous active-low reset
//   instruction    instruction register contents
//   overflow       ALU overflow flag, sampled in EXEC
//   comp_zero      comp register equals zero
//   MemWrite       memory write strobe
//   MemSrc         address select       0=PC 1=SP 2=comp
//   MemDst         write-data select    0=mary 1=shelley 2=ra 3=comp
//   PCSrc          PC source            0=PC+2 1=PC+sext 2=zext 3=ra 4=trap vec
//   SPSrc          SP source            0=SP-2 1=SP+2 2=sext_ls_imm
//   PCWrite/SPWrite/InstWrite           load enables
//   mary_write/shelley_write/comp_write/ra_write  register write enables
//   mary_src/shelley_src/ra_src         register data selects
//   SrcA/SrcB/AluOp                     ALU operand selects and operation
//   in_kernel      kernel-mode flag
//   halted         high while in HALT
//
// state  | meaning
// FETCH  | read instruction at PC, PC <= PC+2
// DECODE | latch opcode, dispatch
// EXEC   | ALU op / address calc / branch / jump
// MEM    | load or store through comp address
// WB     | write ALU result to mary
// TRAP   | PC <= trap vector, enter kernel mode
// HALT   | stopped until reset

module multicycle_control_fsm #(
    parameter bit         TRAP_ON_OVF = 1'b1,
    parameter logic [3:0] HALT_OP     = 4'hF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] instruction,
    input  logic        overflow,
    input  logic        comp_zero,
    output logic        MemWrite,
    output logic [1:0]  MemSrc,
    output logic [2:0]  MemDst,
    output logic [3:0]  PCSrc,
    output logic [1:0]  SPSrc,
    output logic        PCWrite,
    output logic        SPWrite,
    output logic        InstWrite,
    output logic        mary_write,
    output logic        shelley_write,
    output logic        comp_write,
    output logic        ra_write,
    output logic [2:0]  mary_src,
    output logic [1:0]  shelley_src,
    output logic        ra_src,
    output logic        SrcA,
    output logic [1:0]  SrcB,
    output logic [3:0]  AluOp,
    output logic        in_kernel,
    output logic        halted
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [3:0] OP_ALUR  = 4'h0;
    localparam logic [3:0] OP_ALUI  = 4'h1;
    localparam logic [3:0] OP_LOAD  = 4'h2;
    localparam logic [3:0] OP_STORE = 4'h3;
    localparam logic [3:0] OP_BEQZ  = 4'h5;
    localparam logic [3:0] OP_JAL   = 4'h6;
    localparam logic [3:0] OP_JR    = 4'h7;

    state_t     state_q, state_d;
    logic [3:0] opcode_q, opcode_d;
    logic       in_kernel_q, in_kernel_d;
    state_t     trap_target;
    logic [3:0] dec_op;

    // Only the opcode and the ALU function field are decoded here.
    logic unused_instr;
    assign unused_instr = ^{instruction[11:6], instruction[1:0]};

    assign dec_op = instruction[15:12];

    // A second trap while already in kernel mode cannot be serviced.
    assign trap_target = in_kernel_q ? S_HALT : S_TRAP;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_FETCH;
            opcode_q    <= 4'h0;
            in_kernel_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            opcode_q    <= opcode_d;
            in_kernel_q <= in_kernel_d;
        end
    end

    assign opcode_d    = (state_q == S_DECODE) ? dec_op : opcode_q;
    assign in_kernel_d = in_kernel_q | (state_q == S_TRAP);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                if (dec_op == HALT_OP) begin
                    state_d = S_HALT;
                end else begin
                    case (dec_op)
                        OP_ALUR, OP_ALUI, OP_LOAD, OP_STORE,
                        OP_BEQZ, OP_JAL, OP_JR: state_d = S_EXEC;
                        default:                state_d = trap_target;
                    endcase
                end
            end
            S_EXEC: begin
                case (opcode_q)
                    OP_ALUR, OP_ALUI: begin
                        if (overflow && TRAP_ON_OVF) state_d = trap_target;
                        else                         state_d = S_WB;
                    end
                    OP_LOAD, OP_STORE: state_d = S_MEM;
                    default:           state_d = S_FETCH;
                endcase
            end
            S_MEM:  state_d = S_FETCH;
            S_WB:   state_d = S_FETCH;
            S_TRAP: state_d = S_FETCH;
            S_HALT: state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    // Outputs are forced to zero while reset is held so that a mid-instruction
    // reset cannot leak a write enable from the reset value of the state.
    always_comb begin
        MemWrite      = 1'b0;
        MemSrc        = 2'd0;
        MemDst        = 3'd0;
        PCSrc         = 4'd0;
        SPSrc         = 2'd0;
        PCWrite       = 1'b0;
        SPWrite       = 1'b0;
        InstWrite     = 1'b0;
        mary_write    = 1'b0;
        shelley_write = 1'b0;
        comp_write    = 1'b0;
        ra_write      = 1'b0;
        mary_src      = 3'd0;
        shelley_src   = 2'd0;
        ra_src        = 1'b0;
        SrcA          = 1'b0;
        SrcB          = 2'd0;
        AluOp         = 4'd0;
        in_kernel     = 1'b0;
        halted        = 1'b0;
        if (reset) begin
            in_kernel = in_kernel_q;
            case (state_q)
                S_FETCH: begin
                    MemSrc    = 2'd0;
                    InstWrite = 1'b1;
                    PCWrite   = 1'b1;
                    PCSrc     = 4'd0;
                end
                S_EXEC: begin
                    case (opcode_q)
                        OP_ALUR: begin
                            SrcA       = 1'b0;
                            SrcB       = 2'd0;
                            AluOp      = instruction[5:2];
                            comp_write = 1'b1;
                        end
                        OP_ALUI, OP_LOAD, OP_STORE: begin
                            SrcB       = 2'd1;
                            AluOp      = 4'd0;
                            comp_write = 1'b1;
                        end
                        OP_BEQZ: begin
                            if (comp_zero) begin
                                PCWrite = 1'b1;
                                PCSrc   = 4'd1;
                            end
                        end
                        OP_JAL: begin
                            ra_write = 1'b1;
                            ra_src   = 1'b0;
                            PCWrite  = 1'b1;
                            PCSrc    = 4'd2;
                        end
                        OP_JR: begin
                            PCWrite = 1'b1;
                            PCSrc   = 4'd3;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    MemSrc = 2'd2;
                    if (opcode_q == OP_LOAD) begin
                        mary_write = 1'b1;
                        mary_src   = 3'd1;
                    end else begin
                        MemWrite = 1'b1;
                        MemDst   = 3'd0;
                    end
                end
                S_WB: begin
                    mary_write = 1'b1;
                    mary_src   = 3'd0;
                end
                S_TRAP: begin
                    PCWrite = 1'b1;
                    PCSrc   = 4'd4;
                end
                S_HALT: halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule
